// File: rtl/lsu_load_responder_if.sv
// Load-FU request/response and data-memory read port bundle for lsu_load_responder.
// The slave modport is the responder; master is the FU/memory environment.
interface lsu_load_responder_if #(
    parameter int unsigned PA_W     = 40,
    parameter int unsigned ECAUSE_W = 6
);
    logic                flush;
    logic                req_valid;
    logic                req_killed;
    logic [1:0]          req_oper;
    logic [2:0]          req_dtype;
    logic [63:0]         req_vaddr;
    logic                resp_ready;
    logic                resp_done;
    logic [63:0]         resp_data;
    logic                resp_exception;
    logic [ECAUSE_W-1:0] resp_ecause;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [PA_W-1:0]     mem_req_addr;
    logic                mem_resp_valid;
    logic [63:0]         mem_resp_data;
    logic                mem_resp_err;

    modport slave (
        input  flush, req_valid, req_killed, req_oper, req_dtype, req_vaddr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output resp_ready, resp_done, resp_data, resp_exception, resp_ecause,
        output mem_req_valid, mem_req_addr
    );

    modport master (
        output flush, req_valid, req_killed, req_oper, req_dtype, req_vaddr,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  resp_ready, resp_done, resp_data, resp_exception, resp_ecause,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/lsu_load_responder.sv
// LSU load responder: accepts one load from the FU, checks alignment/range, reads an
// aligned doubleword from data memory and returns the extended lane or an exception.
module lsu_load_responder #(
    parameter int unsigned PA_W               = 40,
    parameter int unsigned ECAUSE_W           = 6,
    parameter int unsigned ECAUSE_LD_MISALIGN = 4,
    parameter int unsigned ECAUSE_LD_FAULT    = 5
) (
    input logic                 clk,
    input logic                 rst,
    lsu_load_responder_if.slave bus
);
    localparam logic [1:0] OperLoad = 2'd0;

    typedef enum logic [1:0] {StIdle, StMreq, StMwait, StResp} state_e;

    state_e              state_q;
    logic                kill_q;
    logic [2:0]          dtype_q;
    logic [2:0]          off_q;
    logic                resp_ready_q;
    logic                resp_done_q;
    logic [63:0]         resp_data_q;
    logic                resp_exception_q;
    logic [ECAUSE_W-1:0] resp_ecause_q;
    logic                mem_req_valid_q;
    logic [PA_W-1:0]     mem_req_addr_q;

    logic        accept;
    logic        kill_now;
    logic        misalign;
    logic        range_fault;
    logic [63:0] lane;
    logic [63:0] ext_data;

    assign accept      = bus.req_valid & (bus.req_oper == OperLoad) & ~bus.req_killed
                         & ~bus.flush;
    assign kill_now    = bus.req_killed | bus.flush | ~bus.req_valid;
    assign range_fault = |bus.req_vaddr[63:PA_W];

    always_comb begin
        misalign = 1'b0;
        case (bus.req_dtype)
            3'd1, 3'd5: misalign = bus.req_vaddr[0];
            3'd2, 3'd6: misalign = |bus.req_vaddr[1:0];
            3'd3, 3'd7: misalign = |bus.req_vaddr[2:0];
            default:    misalign = 1'b0;
        endcase
    end

    // Extraction works straight off the memory bus so the result lands in resp_data_q
    // on the same edge that enters StResp.
    always_comb begin
        lane = bus.mem_resp_data >> {off_q, 3'b000};
        case (dtype_q)
            3'd0:    ext_data = {{56{lane[7]}}, lane[7:0]};
            3'd1:    ext_data = {{48{lane[15]}}, lane[15:0]};
            3'd2:    ext_data = {{32{lane[31]}}, lane[31:0]};
            3'd4:    ext_data = {56'd0, lane[7:0]};
            3'd5:    ext_data = {48'd0, lane[15:0]};
            3'd6:    ext_data = {32'd0, lane[31:0]};
            default: ext_data = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            kill_q           <= 1'b0;
            dtype_q          <= 3'd0;
            off_q            <= 3'd0;
            resp_ready_q     <= 1'b0;
            resp_done_q      <= 1'b0;
            resp_data_q      <= 64'd0;
            resp_exception_q <= 1'b0;
            resp_ecause_q    <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_req_addr_q   <= '0;
        end else begin
            // Response fields are only non-zero during the single StResp cycle.
            resp_ready_q     <= 1'b0;
            resp_done_q      <= 1'b0;
            resp_data_q      <= 64'd0;
            resp_exception_q <= 1'b0;
            resp_ecause_q    <= '0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        dtype_q <= bus.req_dtype;
                        off_q   <= bus.req_vaddr[2:0];
                        if (misalign || range_fault) begin
                            state_q          <= StResp;
                            resp_ready_q     <= 1'b1;
                            resp_done_q      <= 1'b1;
                            resp_exception_q <= 1'b1;
                            resp_ecause_q    <= misalign ? ECAUSE_W'(ECAUSE_LD_MISALIGN)
                                                         : ECAUSE_W'(ECAUSE_LD_FAULT);
                        end else begin
                            state_q         <= StMreq;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {bus.req_vaddr[PA_W-1:3], 3'b000};
                        end
                    end
                end
                StMreq: begin
                    if (kill_now) kill_q <= 1'b1;
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= StMwait;
                    end
                end
                StMwait: begin
                    if (kill_now) kill_q <= 1'b1;
                    if (bus.mem_resp_valid) begin
                        state_q <= StResp;
                        // A kill arriving with the response still suppresses it.
                        if (!kill_q && !kill_now) begin
                            resp_ready_q     <= 1'b1;
                            resp_done_q      <= 1'b1;
                            resp_exception_q <= bus.mem_resp_err;
                            resp_ecause_q    <= bus.mem_resp_err ? ECAUSE_W'(ECAUSE_LD_FAULT)
                                                                 : '0;
                            resp_data_q      <= bus.mem_resp_err ? 64'd0 : ext_data;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    kill_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.resp_ready     = resp_ready_q;
    assign bus.resp_done      = resp_done_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.resp_exception = resp_exception_q;
    assign bus.resp_ecause    = resp_ecause_q;
    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_req_addr   = mem_req_addr_q;
endmodule

// File: tb/tb_lsu_load_responder.sv
// Directed bench for lsu_load_responder: vector table of loads plus hand-written
// kill, flush, reset and non-LOAD sequences.
module tb_lsu_load_responder;
    localparam logic [63:0] D0 = 64'h8000_0001_1234_5678;
    localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;

    typedef struct {
        logic [2:0]  dtype;
        logic [63:0] vaddr;
        logic [63:0] mdata;
        logic        merr;
        int          req_wait;
        int          resp_wait;
        logic        fault;
        logic        exc;
        logic [5:0]  cause;
        logic [63:0] data;
        logic [39:0] addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cur = -1;
    vec_t vecs[$];

    always #5 clk = ~clk;

    lsu_load_responder_if #(.PA_W(40), .ECAUSE_W(6)) bus ();

    lsu_load_responder #(
        .PA_W              (40),
        .ECAUSE_W          (6),
        .ECAUSE_LD_MISALIGN(4),
        .ECAUSE_LD_FAULT   (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got 0x%h, expected 0x%h", name, cur, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] dt, input logic [63:0] va,
                                input logic [63:0] md, input logic me, input int rqw,
                                input int rsw, input logic flt, input logic ex,
                                input logic [5:0] ca, input logic [63:0] dat,
                                input logic [39:0] ad);
        vec_t v;
        v.dtype = dt; v.vaddr = va; v.mdata = md; v.merr = me;
        v.req_wait = rqw; v.resp_wait = rsw; v.fault = flt;
        v.exc = ex; v.cause = ca; v.data = dat; v.addr = ad;
        return v;
    endfunction

    task automatic check_resp(input string tag, input vec_t v);
        check({tag, "_done"}, bus.resp_done, 1'b1);
        check({tag, "_ready"}, bus.resp_ready, 1'b1);
        check({tag, "_exc"}, bus.resp_exception, v.exc);
        check({tag, "_cause"}, bus.resp_ecause, v.cause);
        check({tag, "_data"}, bus.resp_data, v.data);
    endtask

    // Presents a load and runs it to completion; memory answers per the vector's waits.
    task automatic do_load(input vec_t v);
        bus.req_valid = 1'b1;
        bus.req_killed = 1'b0;
        bus.req_oper = 2'd0;
        bus.req_dtype = v.dtype;
        bus.req_vaddr = v.vaddr;
        tick();
        if (v.fault) begin
            check("fault_no_memreq", bus.mem_req_valid, 1'b0);
            check_resp("fault", v);
        end else begin
            check("mreq_valid", bus.mem_req_valid, 1'b1);
            check("mreq_addr", bus.mem_req_addr, v.addr);
            for (int i = 0; i < v.req_wait; i++) begin
                tick();
                check("mreq_hold_valid", bus.mem_req_valid, 1'b1);
                check("mreq_hold_addr", bus.mem_req_addr, v.addr);
            end
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready = 1'b0;
            check("mreq_dropped", bus.mem_req_valid, 1'b0);
            for (int i = 0; i < v.resp_wait; i++) tick();
            check("no_early_done", bus.resp_done, 1'b0);
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data = v.mdata;
            bus.mem_resp_err = v.merr;
            tick();
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
            bus.mem_resp_err = 1'b0;
            check_resp("load", v);
        end
        tick();
        check("done_one_cycle", bus.resp_done, 1'b0);
        bus.req_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_killed = 1'b0;
        bus.req_oper = 2'd0;
        bus.req_dtype = 3'd0;
        bus.req_vaddr = 64'd0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.mem_resp_err = 1'b0;

        // dtype: 0=B 1=H 2=W 3=D 4=BU 5=HU 6=WU 7=D
        vecs.push_back(mk(3'd2, 64'h1004, D0, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_8000_0001, 40'h1000));
        vecs.push_back(mk(3'd4, 64'h1007, D0, 0, 1, 0, 0, 0, 0, 64'h80, 40'h1000));
        vecs.push_back(mk(3'd0, 64'h1007, D0, 0, 0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 40'h1000));
        vecs.push_back(mk(3'd1, 64'h1002, D0, 0, 0, 2, 0, 0, 0, 64'h1234, 40'h1000));
        vecs.push_back(mk(3'd5, 64'h1006, D0, 0, 0, 0, 0, 0, 0, 64'h8000, 40'h1000));
        vecs.push_back(mk(3'd1, 64'h1006, D0, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_8000, 40'h1000));
        vecs.push_back(mk(3'd6, 64'h1004, D0, 0, 0, 0, 0, 0, 0, 64'h8000_0001, 40'h1000));
        vecs.push_back(mk(3'd2, 64'h1000, D0, 0, 0, 0, 0, 0, 0, 64'h1234_5678, 40'h1000));
        vecs.push_back(mk(3'd3, 64'h1000, D0, 0, 0, 0, 0, 0, 0, D0, 40'h1000));
        vecs.push_back(mk(3'd0, 64'h1003, D0, 0, 0, 0, 0, 0, 0, 64'h12, 40'h1000));
        vecs.push_back(mk(3'd7, 64'h2008, D1, 0, 2, 1, 0, 0, 0, D1, 40'h2008));
        vecs.push_back(mk(3'd4, 64'hFF_FFFF_FFFF, D0, 0, 0, 0, 0, 0, 0, 64'h80, 40'hFF_FFFF_FFF8));
        vecs.push_back(mk(3'd2, 64'h3000, D0, 1, 3, 0, 0, 1, 5, 64'h0, 40'h3000));
        vecs.push_back(mk(3'd3, 64'h1004, D0, 0, 0, 0, 1, 1, 4, 64'h0, 40'h0));
        vecs.push_back(mk(3'd3, 64'h0100_0000_0000, D0, 0, 0, 0, 1, 1, 5, 64'h0, 40'h0));
        vecs.push_back(mk(3'd1, 64'h1001, D0, 0, 0, 0, 1, 1, 4, 64'h0, 40'h0));
        vecs.push_back(mk(3'd2, 64'h0100_0000_0002, D0, 0, 0, 0, 1, 1, 4, 64'h0, 40'h0));
        vecs.push_back(mk(3'd0, 64'h8000_0000_0000_0000, D0, 0, 0, 0, 1, 1, 5, 64'h0, 40'h0));

        tick();
        tick();
        check("rst_done", bus.resp_done, 1'b0);
        check("rst_ready", bus.resp_ready, 1'b0);
        check("rst_mreq", bus.mem_req_valid, 1'b0);
        check("rst_addr", bus.mem_req_addr, 40'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            do_load(vecs[i]);
        end

        // Kill in MWAIT, late memory response absorbed, held LD accepted only afterwards.
        cur = 100;
        bus.req_valid = 1'b1;
        bus.req_oper = 2'd0;
        bus.req_dtype = 3'd2;
        bus.req_vaddr = 64'h1004;
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.req_killed = 1'b1;
        tick();
        bus.req_killed = 1'b0;
        bus.req_dtype = 3'd3;
        bus.req_vaddr = 64'h1008;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("kill_no_accept", bus.mem_req_valid, 1'b0);
            check("kill_no_done", bus.resp_done, 1'b0);
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = D0;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        check("kill_suppressed", bus.resp_done, 1'b0);
        check("kill_suppressed_ready", bus.resp_ready, 1'b0);
        check("kill_still_busy", bus.mem_req_valid, 1'b0);
        tick();
        do_load(mk(3'd3, 64'h1008, D1, 0, 0, 0, 0, 0, 0, D1, 40'h1008));

        // Reset during MREQ; a stray memory response afterwards must be ignored.
        cur = 101;
        bus.req_valid = 1'b1;
        bus.req_dtype = 3'd2;
        bus.req_vaddr = 64'h4004;
        tick();
        check("pre_rst_mreq", bus.mem_req_valid, 1'b1);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_mid_mreq", bus.mem_req_valid, 1'b0);
        check("rst_mid_addr", bus.mem_req_addr, 40'h0);
        check("rst_mid_done", bus.resp_done, 1'b0);
        check("rst_mid_exc", bus.resp_exception, 1'b0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = D0;
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        check("stray_resp_ignored", bus.resp_done, 1'b0);
        do_load(mk(3'd6, 64'h4004, D0, 0, 0, 0, 0, 0, 0, 64'h8000_0001, 40'h4000));

        // Flush arriving together with the memory response suppresses resp_done.
        cur = 102;
        bus.req_valid = 1'b1;
        bus.req_dtype = 3'd3;
        bus.req_vaddr = 64'h5000;
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.flush = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = D0;
        tick();
        bus.flush = 1'b0;
        bus.mem_resp_valid = 1'b0;
        check("flush_suppressed", bus.resp_done, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        tick();

        // Flush in IDLE and non-LOAD opers must not start a transaction.
        cur = 103;
        bus.req_valid = 1'b1;
        bus.flush = 1'b1;
        tick();
        check("flush_idle_no_accept", bus.mem_req_valid, 1'b0);
        bus.flush = 1'b0;
        bus.req_oper = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nonload_no_mreq", bus.mem_req_valid, 1'b0);
            check("nonload_no_done", bus.resp_done, 1'b0);
        end
        bus.req_valid = 1'b0;
        bus.req_oper = 2'd0;
        tick();
        do_load(mk(3'd0, 64'h5001, D0, 0, 0, 0, 0, 0, 0, 64'h56, 40'h5000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
